// File: rtl/mem_arbiter.sv
// Two-requester (CPU, DMA) arbiter in front of a single-port data memory.
// Latency: grant is combinational in the request cycle; read data returns one cycle later.
// Backpressure: a requester holds its request until granted; a DMA lock burst can stall the CPU for at most MAX_BURST grants.
module mem_arbiter #(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        reset,
  // CPU port
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_wd,
  output logic        cpu_gnt,
  output logic [31:0] cpu_rd,
  output logic        cpu_rvalid,
  // DMA / loader port
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_adr,
  input  logic [31:0] dma_wd,
  input  logic        dma_lock,
  output logic        dma_gnt,
  output logic [31:0] dma_rd,
  output logic        dma_rvalid,
  // data memory (synchronous write, combinational read)
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  // status
  output logic        locked
);

  typedef enum logic [0:0] {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Counter value at which the current DMA grant is the last one of a burst.
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  state_e      state_q;
  logic [7:0]  burst_cnt_q;
  logic        last_dma_q;     // 1: DMA was granted most recently
  logic        cpu_rvalid_q;
  logic        dma_rvalid_q;
  logic [31:0] cpu_rd_q;
  logic [31:0] dma_rd_q;

  // Grant selection: lock owner first, otherwise round-robin on contention.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!reset) begin
      if (state_q == ST_LOCKED) begin
        // A dropped dma_req ends the burst; the CPU may use that idle slot.
        if (dma_req)      dma_gnt = 1'b1;
        else if (cpu_req) cpu_gnt = 1'b1;
      end else if (cpu_req && dma_req) begin
        if (last_dma_q) cpu_gnt = 1'b1;
        else            dma_gnt = 1'b1;
      end else begin
        cpu_gnt = cpu_req;
        dma_gnt = dma_req;
      end
    end
  end

  // Memory port mux from the granted requester; all zero when idle.
  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    if (cpu_gnt) begin
      mem_we = cpu_we;
      mem_a  = cpu_adr;
      mem_wd = cpu_wd;
    end else if (dma_gnt) begin
      mem_we = dma_we;
      mem_a  = dma_adr;
      mem_wd = dma_wd;
    end
  end

  // Arbitration FSM, burst counter, fairness pointer and read-return registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_OPEN;
      burst_cnt_q  <= '0;
      last_dma_q   <= 1'b1;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      cpu_rd_q     <= '0;
      dma_rd_q     <= '0;
    end else begin
      // Read return: capture memory data for a granted read, pulse rvalid once.
      cpu_rvalid_q <= cpu_gnt && !cpu_we;
      dma_rvalid_q <= dma_gnt && !dma_we;
      if (cpu_gnt && !cpu_we) cpu_rd_q <= mem_rd;
      if (dma_gnt && !dma_we) dma_rd_q <= mem_rd;

      if (cpu_gnt) last_dma_q <= 1'b0;
      if (dma_gnt) last_dma_q <= 1'b1;

      case (state_q)
        ST_OPEN: begin
          if (dma_gnt && dma_lock) begin
            state_q     <= ST_LOCKED;
            burst_cnt_q <= 8'd1;
          end
        end
        ST_LOCKED: begin
          if (!dma_req || !dma_lock || burst_cnt_q == BURST_LAST) begin
            // Burst over: idle DMA, explicit release, or burst length cap.
            // last_dma_q is already DMA here, so a waiting CPU wins next.
            state_q     <= ST_OPEN;
            burst_cnt_q <= '0;
          end else begin
            burst_cnt_q <= burst_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q     <= ST_OPEN;
          burst_cnt_q <= '0;
        end
      endcase
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign dma_rvalid = dma_rvalid_q;
  assign cpu_rd     = cpu_rd_q;
  assign dma_rd     = dma_rd_q;
  assign locked     = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
  logic [31:0] cpu_adr, cpu_wd, dma_adr, dma_wd;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [31:0] cpu_rd, dma_rd;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        locked;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          is_dma;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  bit wrote8 = 1'b0;

  mem_arbiter #(.MAX_BURST(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
    .cpu_gnt(cpu_gnt), .cpu_rd(cpu_rd), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wd(dma_wd),
    .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rd(dma_rd), .dma_rvalid(dma_rvalid),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: unwritten words hold a fixed pattern, 0x40 holds 0xDEADBEEF.
  function automatic logic [31:0] init_val(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [31:0] exp_val(input logic [31:0] a);
    if (a == 32'h8 && wrote8) return 32'h0000_0055;
    return init_val(a);
  endfunction

  logic [31:0] mem_arr [0:255];
  bit   [255:0] wr_flag;
  initial wr_flag = '0;
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      mem_arr[mem_a[9:2]] <= mem_wd;
      wr_flag[mem_a[9:2]] <= 1'b1;
    end
  end
  assign mem_rd = wr_flag[mem_a[9:2]] ? mem_arr[mem_a[9:2]] : init_val(mem_a);

  // Read-return scoreboard.
  always @(negedge clk) begin
    if (cpu_rvalid === 1'b1 || dma_rvalid === 1'b1) begin
      checks++;
      if (cpu_rvalid === 1'b1 && dma_rvalid === 1'b1) begin
        errors++;
        $display("FAIL sb_both_rvalid: cpu_rvalid=1 dma_rvalid=1, required at most one");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: cpu_rvalid=%b dma_rvalid=%b, required no rvalid", cpu_rvalid, dma_rvalid);
      end else begin
        exp_t e;
        bit got_dma;
        logic [31:0] got;
        e = exp_q.pop_front();
        got_dma = (dma_rvalid === 1'b1);
        got = got_dma ? dma_rd : cpu_rd;
        if (got_dma !== e.is_dma || got !== e.data) begin
          errors++;
          $display("FAIL sb_read: got dma=%0b rd=%h, required dma=%0b rd=%h", got_dma, got, e.is_dma, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic drive(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                       input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dd,
                       input bit dl);
    cpu_req = cr; cpu_we = cw; cpu_adr = ca; cpu_wd = cd;
    dma_req = dr; dma_we = dw; dma_adr = da; dma_wd = dd; dma_lock = dl;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
  endtask

  task automatic push_exp(input bit is_dma, input logic [31:0] a);
    exp_t e;
    e.is_dma = is_dma;
    e.data   = exp_val(a);
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 1, 32'h4, 32'h99, 1, 1, 32'hC, 32'h77, 1);
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b0 || dma_gnt !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_gnt: cpu_gnt=%b dma_gnt=%b mem_we=%b, required 0 0 0", cpu_gnt, dma_gnt, mem_we);
    end
    checks++;
    if (locked !== 1'b0 || cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0 || cpu_rd !== 32'h0 || dma_rd !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: locked=%b rv=%b/%b rd=%h/%h, required all 0", locked, cpu_rvalid, dma_rvalid, cpu_rd, dma_rd);
    end
    next_cycle();
    reset = 1'b0;
    idle();
    @(negedge clk);
    checks++;
    if (locked !== 1'b0 || cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0 || mem_a !== 32'h0) begin
      errors++;
      $display("FAIL reset_release: locked=%b rv=%b/%b mem_a=%h, required 0", locked, cpu_rvalid, dma_rvalid, mem_a);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) begin
      bit exp_c;
      logic [31:0] exp_a;
      exp_c = (i % 2 == 0);
      exp_a = exp_c ? 32'h10 : 32'h20;
      drive(1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0, 0);
      push_exp(!exp_c, exp_a);
      @(negedge clk);
      checks++;
      if (cpu_gnt !== exp_c || dma_gnt !== !exp_c || mem_a !== exp_a || mem_we !== 1'b0) begin
        errors++;
        $display("FAIL rr_cycle%0d: cpu_gnt=%b dma_gnt=%b mem_a=%h, required %b %b %h", i, cpu_gnt, dma_gnt, mem_a, exp_c, !exp_c, exp_a);
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_cpu_read();
    drive(1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    push_exp(0, 32'h40);
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0 || mem_a !== 32'h40 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_gnt: cpu_gnt=%b dma_gnt=%b mem_a=%h, required 1 0 00000040", cpu_gnt, dma_gnt, mem_a);
    end
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rd !== 32'hDEADBEEF || dma_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_data: rvalid=%b rd=%h dma_rvalid=%b, required 1 deadbeef 0", cpu_rvalid, cpu_rd, dma_rvalid);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b0 || cpu_rd !== 32'hDEADBEEF || dma_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_hold: rvalid=%b rd=%h dma_rvalid=%b, required 0 deadbeef 0", cpu_rvalid, cpu_rd, dma_rvalid);
    end
    next_cycle();
  endtask

  task automatic test_burst();
    // CPU was granted last, so DMA wins the first contention and locks.
    for (int i = 1; i <= 9; i++) begin
      drive(1, 0, 32'h30, 32'h0, 1, 1, 32'h8, 32'h55, 1);
      @(negedge clk);
      checks++;
      if (i <= 8) begin
        if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0 || mem_we !== 1'b1 || mem_a !== 32'h8 ||
            mem_wd !== 32'h55 || locked !== (i >= 2)) begin
          errors++;
          $display("FAIL burst_cycle%0d: dma_gnt=%b cpu_gnt=%b we=%b a=%h wd=%h locked=%b, required 1 0 1 8 55 %b",
                   i, dma_gnt, cpu_gnt, mem_we, mem_a, mem_wd, locked, (i >= 2));
        end
      end else begin
        push_exp(0, 32'h30);
        if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0 || locked !== 1'b0 || mem_a !== 32'h30 || mem_we !== 1'b0) begin
          errors++;
          $display("FAIL burst_cpu_cycle9: cpu_gnt=%b dma_gnt=%b locked=%b a=%h, required 1 0 0 30", cpu_gnt, dma_gnt, locked, mem_a);
        end
      end
      next_cycle();
    end
    wrote8 = 1'b1;
    drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h8, 32'h55, 0);
    @(negedge clk);
    checks++;
    if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
      errors++;
      $display("FAIL burst_tail: dma_gnt=%b cpu_gnt=%b, required 1 0", dma_gnt, cpu_gnt);
    end
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL burst_unlocked: locked=%b, required 0", locked);
    end
    next_cycle();
  endtask

  task automatic test_lock_release();
    // c1: DMA alone locks; c2: locked, CPU waits; c3: release still granted;
    // c4: contention goes to CPU; c5: DMA reads back the burst write.
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0, 1);
    push_exp(1, 32'h20);
    @(negedge clk);
    checks++;
    if (dma_gnt !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL rel_c1: dma_gnt=%b locked=%b, required 1 0", dma_gnt, locked);
    end
    next_cycle();
    drive(1, 0, 32'h10, 32'h0, 1, 0, 32'h24, 32'h0, 1);
    push_exp(1, 32'h24);
    @(negedge clk);
    checks++;
    if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL rel_c2: dma_gnt=%b cpu_gnt=%b locked=%b, required 1 0 1", dma_gnt, cpu_gnt, locked);
    end
    next_cycle();
    drive(1, 0, 32'h10, 32'h0, 1, 0, 32'h28, 32'h0, 0);
    push_exp(1, 32'h28);
    @(negedge clk);
    checks++;
    if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL rel_c3: dma_gnt=%b cpu_gnt=%b locked=%b, required 1 0 1", dma_gnt, cpu_gnt, locked);
    end
    next_cycle();
    drive(1, 0, 32'h10, 32'h0, 1, 0, 32'h8, 32'h0, 0);
    push_exp(0, 32'h10);
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL rel_c4: cpu_gnt=%b dma_gnt=%b locked=%b, required 1 0 0", cpu_gnt, dma_gnt, locked);
    end
    next_cycle();
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h8, 32'h0, 0);
    push_exp(1, 32'h8);
    @(negedge clk);
    checks++;
    if (dma_gnt !== 1'b1 || mem_a !== 32'h8) begin
      errors++;
      $display("FAIL rel_c5: dma_gnt=%b mem_a=%h, required 1 00000008", dma_gnt, mem_a);
    end
    next_cycle();
    idle();
  endtask

  task automatic test_reset_read();
    // Make CPU the most recent winner so a post-reset CPU win proves the pointer reset.
    drive(1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    push_exp(0, 32'h40);
    next_cycle();
    reset = 1'b1;
    drive(1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0, 0);
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b0 || dma_gnt !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL rstrd_gnt: cpu_gnt=%b dma_gnt=%b mem_we=%b, required 0 0 0", cpu_gnt, dma_gnt, mem_we);
    end
    next_cycle();
    reset = 1'b0;
    push_exp(0, 32'h10);
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0 || cpu_rd !== 32'h0 || dma_rd !== 32'h0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL rstrd_state: rv=%b/%b rd=%h/%h locked=%b, required 0 0 0 0 0", cpu_rvalid, dma_rvalid, cpu_rd, dma_rd, locked);
    end
    checks++;
    if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rstrd_first_win: cpu_gnt=%b dma_gnt=%b, required 1 0", cpu_gnt, dma_gnt);
    end
    next_cycle();
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0, 0);
    push_exp(1, 32'h20);
    next_cycle();
    idle();
    next_cycle();
  endtask

  task automatic test_idle();
    idle();
    next_cycle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0 || mem_a !== 32'h0 || mem_wd !== 32'h0 || cpu_gnt !== 1'b0 || dma_gnt !== 1'b0 ||
          cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL idle_cycle%0d: we=%b a=%h wd=%h gnt=%b/%b rv=%b/%b, required all 0",
                 i, mem_we, mem_a, mem_wd, cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid);
      end
      next_cycle();
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    next_cycle();
    test_reset();
    test_round_robin();
    test_cpu_read();
    test_burst();
    test_lock_release();
    test_reset_read();
    test_idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d reads outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
